// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU (operands plus funct3/funct7[5]/ALUOp decode) between two
// requesters. An accepted op is registered, executed for one cycle, and its result is held until the owner takes it.
module alu_share_arbiter #(
  parameter int XLEN = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic [1:0]        req_valid_i,
  output logic [1:0]        req_ready_o,
  input  logic [5:0]        req_funct3_i,
  input  logic [1:0]        req_funct7_bit5_i,
  input  logic [3:0]        req_aluop_i,
  input  logic [2*XLEN-1:0] req_a_i,
  input  logic [2*XLEN-1:0] req_b_i,
  output logic [2:0]        alu_funct3_o,
  output logic              alu_funct7_bit5_o,
  output logic [1:0]        alu_aluop_o,
  output logic [XLEN-1:0]   alu_a_o,
  output logic [XLEN-1:0]   alu_b_o,
  input  logic [XLEN-1:0]   alu_result_i,
  input  logic              alu_zero_i,
  output logic [1:0]        rsp_valid_o,
  input  logic [1:0]        rsp_ready_i,
  output logic [XLEN-1:0]   rsp_data_o,
  output logic              rsp_zero_o,
  output logic              busy_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]      r_state;
  logic            r_grant;
  logic            r_last_grant;
  logic [2:0]      r_funct3;
  logic            r_funct7_bit5;
  logic [1:0]      r_aluop;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_rsp_data;
  logic            r_rsp_zero;

  logic            w_rsp_hs;
  logic            w_gnt;
  logic            w_grant_en;

  // Arbitration: on a tie the requester that did not win last time goes next.
  always_comb begin
    w_rsp_hs   = (r_state == S_RESP) && rsp_ready_i[r_grant];
    w_gnt      = (req_valid_i == 2'b11) ? ~r_last_grant : req_valid_i[1];
    w_grant_en = !rst_i && !flush_i && (req_valid_i != 2'b00) &&
                 ((r_state == S_IDLE) || w_rsp_hs);
    if (w_grant_en) begin
      req_ready_o = w_gnt ? 2'b10 : 2'b01;
    end else begin
      req_ready_o = 2'b00;
    end
    if (r_state == S_RESP) begin
      rsp_valid_o = r_grant ? 2'b10 : 2'b01;
    end else begin
      rsp_valid_o = 2'b00;
    end
    busy_o = (r_state != S_IDLE);
  end

  assign alu_funct3_o      = r_funct3;
  assign alu_funct7_bit5_o = r_funct7_bit5;
  assign alu_aluop_o       = r_aluop;
  assign alu_a_o           = r_a;
  assign alu_b_o           = r_b;
  assign rsp_data_o        = r_rsp_data;
  assign rsp_zero_o        = r_rsp_zero;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= S_IDLE;
      r_grant       <= 1'b0;
      r_last_grant  <= 1'b1;
      r_funct3      <= 3'd0;
      r_funct7_bit5 <= 1'b0;
      r_aluop       <= 2'd0;
      r_a           <= '0;
      r_b           <= '0;
      r_rsp_data    <= '0;
      r_rsp_zero    <= 1'b0;
    end else if (flush_i) begin
      // Drop the in-flight op; the last captured result stays readable.
      r_state <= S_IDLE;
    end else begin
      if (w_grant_en) begin
        r_grant       <= w_gnt;
        r_last_grant  <= w_gnt;
        r_funct3      <= w_gnt ? req_funct3_i[5:3] : req_funct3_i[2:0];
        r_funct7_bit5 <= w_gnt ? req_funct7_bit5_i[1] : req_funct7_bit5_i[0];
        r_aluop       <= w_gnt ? req_aluop_i[3:2] : req_aluop_i[1:0];
        r_a           <= w_gnt ? req_a_i[2*XLEN-1:XLEN] : req_a_i[XLEN-1:0];
        r_b           <= w_gnt ? req_b_i[2*XLEN-1:XLEN] : req_b_i[XLEN-1:0];
      end
      case (r_state)
        S_IDLE: begin
          r_state <= w_grant_en ? S_EXEC : S_IDLE;
        end
        S_EXEC: begin
          r_rsp_data <= alu_result_i;
          r_rsp_zero <= alu_zero_i;
          r_state    <= S_RESP;
        end
        S_RESP: begin
          if (w_grant_en) begin
            r_state <= S_EXEC;
          end else if (w_rsp_hs) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_RESP;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a behavioural ALU plus a transaction-level model of
// acceptance, latency-2 responses, round-robin order, flush and reset.
module tb_alu_share_arbiter;
  localparam int XLEN = 32;

  logic              clk_i = 1'b0;
  logic              rst_i, flush_i;
  logic [1:0]        req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
  logic [5:0]        req_funct3_i;
  logic [1:0]        req_funct7_bit5_i;
  logic [3:0]        req_aluop_i;
  logic [2*XLEN-1:0] req_a_i, req_b_i;
  logic [2:0]        alu_funct3_o;
  logic              alu_funct7_bit5_o, alu_zero_i, rsp_zero_o, busy_o;
  logic [1:0]        alu_aluop_o;
  logic [XLEN-1:0]   alu_a_o, alu_b_o, alu_result_i, rsp_data_o;

  logic [2:0]      f3 [2];
  logic            f7 [2];
  logic [1:0]      op [2];
  logic [XLEN-1:0] a  [2];
  logic [XLEN-1:0] b  [2];

  always #5 clk_i = ~clk_i;

  assign req_funct3_i      = {f3[1], f3[0]};
  assign req_funct7_bit5_i = {f7[1], f7[0]};
  assign req_aluop_i       = {op[1], op[0]};
  assign req_a_i           = {a[1], a[0]};
  assign req_b_i           = {b[1], b[0]};

  function automatic logic [XLEN-1:0] alu_ref(input logic [1:0] o, input logic [2:0] fn3,
                                              input logic fn7, input logic [XLEN-1:0] x,
                                              input logic [XLEN-1:0] y);
    if (o == 2'b00) return x + y;
    if (o == 2'b01) return x - y;
    if (o == 2'b11) return x;
    case (fn3)
      3'b000:  return fn7 ? x - y : x + y;
      3'b001:  return x << y[4:0];
      3'b010:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'b011:  return (x < y) ? 32'd1 : 32'd0;
      3'b100:  return x ^ y;
      3'b101:  return fn7 ? XLEN'($signed(x) >>> y[4:0]) : x >> y[4:0];
      3'b110:  return x | y;
      default: return x & y;
    endcase
  endfunction

  assign alu_result_i = alu_ref(alu_aluop_o, alu_funct3_o, alu_funct7_bit5_o, alu_a_o, alu_b_o);
  assign alu_zero_i   = (alu_result_i == 32'd0);

  alu_share_arbiter #(.XLEN(XLEN)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_funct3_i(req_funct3_i), .req_funct7_bit5_i(req_funct7_bit5_i),
    .req_aluop_i(req_aluop_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
    .alu_funct3_o(alu_funct3_o), .alu_funct7_bit5_o(alu_funct7_bit5_o),
    .alu_aluop_o(alu_aluop_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_zero_o(rsp_zero_o), .busy_o(busy_o)
  );

  int n_pass = 0;
  int n_total = 0;

  // Model: at most one outstanding op, accepted at cycle out_acc, responding from out_acc+2.
  int              t;
  bit              out_v;
  int              out_who, out_acc, last;
  logic [XLEN-1:0] out_data, m_data, m_a, m_b;
  bit              m_zero, m_f7;
  logic [2:0]      m_f3;
  logic [1:0]      m_op, obs_rdy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s (cycle %0d): got %0h expected %0h", tag, t, obs, exp);
    end
  endtask

  task automatic model_reset();
    out_v = 1'b0; out_who = 0; out_acc = 0; last = 1;
    m_data = '0; m_zero = 1'b0; m_a = '0; m_b = '0;
    m_f3 = 3'd0; m_f7 = 1'b0; m_op = 2'd0;
  endtask

  task automatic step(input logic [1:0] v, input logic [1:0] rr, input logic fl, input logic rs);
    logic [1:0] e_rv, e_rdy;
    bit hs, gok;
    int win;
    req_valid_i = v; rsp_ready_i = rr; flush_i = fl; rst_i = rs;
    @(negedge clk_i);
    e_rv  = (out_v && t >= out_acc + 2) ? (out_who == 1 ? 2'b10 : 2'b01) : 2'b00;
    hs    = (e_rv != 2'b00) && rr[out_who];
    gok   = !rs && !fl && (v != 2'b00) && (!out_v || hs);
    win   = (v == 2'b11) ? 1 - last : (v[1] ? 1 : 0);
    e_rdy = gok ? (win == 1 ? 2'b10 : 2'b01) : 2'b00;
    obs_rdy = req_ready_o;
    chk("req_ready", req_ready_o, e_rdy);
    chk("rsp_valid", rsp_valid_o, e_rv);
    chk("busy", busy_o, out_v);
    chk("rsp_data", rsp_data_o, m_data);
    chk("rsp_zero", rsp_zero_o, m_zero);
    chk("alu_a", alu_a_o, m_a);
    chk("alu_b", alu_b_o, m_b);
    chk("alu_decode", {alu_funct3_o, alu_funct7_bit5_o, alu_aluop_o}, {m_f3, m_f7, m_op});
    if (rs) begin
      model_reset();
    end else if (fl) begin
      out_v = 1'b0;
    end else begin
      if (out_v && t == out_acc + 1) begin
        m_data = out_data;
        m_zero = (out_data == 32'd0);
      end
      if (hs) out_v = 1'b0;
      if (gok) begin
        out_v = 1'b1; out_who = win; out_acc = t; last = win;
        m_f3 = f3[win]; m_f7 = f7[win]; m_op = op[win]; m_a = a[win]; m_b = b[win];
        out_data = alu_ref(op[win], f3[win], f7[win], a[win], b[win]);
      end
    end
    t++;
    @(posedge clk_i); #1;
  endtask

  task automatic set_op(input int k, input logic [1:0] o, input logic [2:0] fn3,
                        input logic fn7, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
    op[k] = o; f3[k] = fn3; f7[k] = fn7; a[k] = x; b[k] = y;
  endtask

  task automatic rand_ops();
    for (int k = 0; k < 2; k++) begin
      op[k] = 2'($urandom_range(0, 3));
      f3[k] = 3'($urandom_range(0, 7));
      f7[k] = 1'($urandom_range(0, 1));
      a[k]  = $urandom;
      b[k]  = ($urandom_range(0, 3) == 0) ? a[k] : $urandom;
    end
  endtask

  initial begin
    t = 0;
    model_reset();
    set_op(0, 2'b00, 3'd0, 1'b0, 32'd0, 32'd0);
    set_op(1, 2'b00, 3'd0, 1'b0, 32'd0, 32'd0);
    req_valid_i = 2'b00; rsp_ready_i = 2'b00; flush_i = 1'b0; rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    step(2'b00, 2'b00, 1'b0, 1'b1);
    step(2'b00, 2'b00, 1'b0, 1'b0);

    // Req0 alone: 5 + 7 through the R-type add path.
    set_op(0, 2'b10, 3'b000, 1'b0, 32'd5, 32'd7);
    step(2'b01, 2'b00, 1'b0, 1'b0);
    chk("tp1_accept", obs_rdy, 2'b01);
    step(2'b00, 2'b00, 1'b0, 1'b0);
    chk("tp1_data", rsp_data_o, 32'd12);
    chk("tp1_zero", rsp_zero_o, 1'b0);
    step(2'b00, 2'b01, 1'b0, 1'b0);

    // Simultaneous requests straight after reset: req0 first, then req1.
    step(2'b00, 2'b00, 1'b0, 1'b1);
    set_op(0, 2'b01, 3'b000, 1'b0, 32'd9, 32'd9);
    set_op(1, 2'b00, 3'b000, 1'b0, 32'd3, 32'd4);
    step(2'b11, 2'b11, 1'b0, 1'b0);
    chk("tp2_first_grant", obs_rdy, 2'b01);
    step(2'b10, 2'b11, 1'b0, 1'b0);
    chk("tp2_data0", rsp_data_o, 32'd0);
    chk("tp2_zero0", rsp_zero_o, 1'b1);
    step(2'b10, 2'b11, 1'b0, 1'b0);
    chk("tp2_second_grant", obs_rdy, 2'b10);
    step(2'b00, 2'b11, 1'b0, 1'b0);
    chk("tp2_data1", rsp_data_o, 32'd7);
    step(2'b00, 2'b11, 1'b0, 1'b0);

    // Both continuously valid: alternating grants every second cycle.
    for (int i = 0; i < 12; i++) begin
      rand_ops();
      step(2'b11, 2'b11, 1'b0, 1'b0);
    end
    step(2'b00, 2'b11, 1'b0, 1'b0);

    // Backpressure for five cycles; the other requester's ready is ignored.
    rand_ops();
    step(2'b01, 2'b00, 1'b0, 1'b0);
    step(2'b00, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(2'b11, (i == 4) ? 2'b10 : 2'b00, 1'b0, 1'b0);
    step(2'b00, 2'b01, 1'b0, 1'b0);
    step(2'b00, 2'b00, 1'b0, 1'b0);

    // Flush in EXEC, then in RESP; each followed by a clean transaction.
    for (int ph = 0; ph < 2; ph++) begin
      rand_ops();
      step(2'b10, 2'b00, 1'b0, 1'b0);
      if (ph == 1) step(2'b00, 2'b00, 1'b0, 1'b0);
      step(2'b00, 2'b00, 1'b1, 1'b0);
      step(2'b00, 2'b11, 1'b0, 1'b0);
      rand_ops();
      step(2'b01, 2'b11, 1'b0, 1'b0);
      step(2'b00, 2'b11, 1'b0, 1'b0);
      step(2'b00, 2'b11, 1'b0, 1'b0);
    end

    // Reset in EXEC, then a tie must go to requester 0.
    rand_ops();
    step(2'b10, 2'b00, 1'b0, 1'b0);
    step(2'b00, 2'b00, 1'b0, 1'b1);
    step(2'b11, 2'b11, 1'b0, 1'b0);
    chk("tp6_tie_after_reset", obs_rdy, 2'b01);
    step(2'b00, 2'b11, 1'b0, 1'b0);
    step(2'b00, 2'b11, 1'b0, 1'b0);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 500; i++) begin
      rand_ops();
      step(2'($urandom_range(0, 3)),
           ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom_range(1, 3)),
           1'($urandom_range(0, 24) == 0),
           1'($urandom_range(0, 99) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the core's single ALU, together with its funct3/funct7/ALUOp decode path, between two requesters. Requester 0 is the main execute path; requester 1 is the address-generation/debug port.
- Arbitration is round-robin with a valid/ready request handshake.
- The block drives the ALU decode inputs and operands from registered fields, captures the result and returns it over a per-requester valid/ready response handshake.

Parameters:
XLEN, 32, operand/result width

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  synchronous active-high reset
flush_i  input  1  synchronous abort of the in-flight op
req_valid_i  input  2  request valid, bit k = requester k
req_ready_o  output  2  request accepted this cycle (one-hot or zero)
req_funct3_i  input  6  funct3, requester k at [3k+2:3k]
req_funct7_bit5_i  input  2  funct7[5], bit k
req_aluop_i  input  4  ALUOp, requester k at [2k+1:2k]
req_a_i  input  2*XLEN  operand A, requester k at [k*XLEN +: XLEN]
req_b_i  input  2*XLEN  operand B, same packing
alu_funct3_o  output  3  to ALU decode
alu_funct7_bit5_o  output  1  to ALU decode
alu_aluop_o  output  2  to ALU decode
alu_a_o  output  XLEN  ALU operand A
alu_b_o  output  XLEN  ALU operand B
alu_result_i  input  XLEN  ALU result (combinational from alu_* outputs)
alu_zero_i  input  1  ALU zero flag
rsp_valid_o  output  2  response valid, one-hot to granted requester
rsp_ready_i  input  2  response ready, bit k
rsp_data_o  output  XLEN  registered result
rsp_zero_o  output  1  registered zero flag
busy_o  output  1  high in EXEC or RESP

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset values:
  - state IDLE; grant register 0; last_grant 1 (requester 0 wins the first tie).
  - All op registers, rsp_data_o and rsp_zero_o are 0.
  - req_ready_o, rsp_valid_o and busy_o are 0.
- IDLE:
  - If any req_valid_i bit is set, grant per round-robin.
  - Priority goes to the requester other than last_grant; if only one is valid, it wins.
  - req_ready_o[g]=1 combinationally in the same cycle.
  - At the clock edge, latch funct3, funct7_bit5, ALUOp, A and B of g into op registers; set last_grant=g; go to EXEC.
- EXEC:
  - alu_* outputs equal the op registers (always registered, never combinational from req_*).
  - At the clock edge, capture alu_result_i into rsp_data_o and alu_zero_i into rsp_zero_o; go to RESP.
- RESP:
  - rsp_valid_o[g]=1, held with data stable until rsp_ready_i[g]=1.
  - On the handshake, if any req_valid_i bit is set, perform the IDLE grant in the same cycle (req_ready_o asserted, go to EXEC); otherwise go to IDLE.
  - rsp_ready_i of the non-granted requester is ignored.
- Latency: request accepted in cycle N -> ALU driven in N+1 -> rsp_valid_o in N+2. Peak throughput is one op per 2 cycles with rsp_ready_i held high.
- req_ready_o is 0 in EXEC, and in RESP unless the response handshake completes that cycle. No request is ever accepted while a result is pending.
- alu_* outputs hold their last op-register values outside EXEC. Consumers must qualify them with busy_o.
- flush_i:
  - Highest priority after rst_i. From any state, go to IDLE at the next edge.
  - The pending response is dropped: rsp_valid_o=0 from the next cycle on.
  - req_ready_o is forced to 0 in the flush cycle.
  - last_grant is unchanged; rsp_data_o holds its value.
- rst_i mid-operation: all state returns to reset values at the next edge and no response is issued.
- Arithmetic: no width changes. Data passes through at XLEN bits and no flags are derived other than alu_zero_i.

Test Plan:
- Req0 only: ALUOp=10, funct3=000, f7b5=0, A=5, B=7 -> req_ready_o=01 in cycle N; alu_a_o=5, alu_b_o=7 in N+1; rsp_valid_o=01, rsp_data_o=12, rsp_zero_o=0 in N+2.
- Both valid in the same cycle after reset: req0 A=9,B=9 SUB (ALUOp=01); req1 A=3,B=4 ADD (ALUOp=00) -> req0 is granted first with rsp_data_o=0, rsp_zero_o=1. With rsp_ready_i=11, req1 is granted in the handshake cycle and returns 7 two cycles later.
- Both requesters continuously valid for 6 grants with rsp_ready_i=11 -> grant order 0,1,0,1,0,1; rsp_valid_o asserted on every 2nd cycle.
- Backpressure: rsp_ready_i=00 for 5 cycles in RESP -> rsp_valid_o and rsp_data_o stable and req_ready_o=00 throughout; the handshake completes on the cycle rsp_ready_i[g]=1.
- flush_i pulsed in EXEC, and separately in RESP -> IDLE next cycle; no rsp_valid_o pulse; the next request returns a correct result with latency 2.
- rst_i asserted in EXEC -> all outputs 0 next cycle; after release, a simultaneous request from both requesters grants requester 0 first.
